pcie_host_requester: RTL and testbench

Host-side requester model that drives the simplified PCIe link packet interface of the endpoint's BAR0 bridge.
- Queues local read/write commands and serialises them into 64-bit link packets.
- Tracks one outstanding read at a time and waits for its completion, with a timeout.
- Returns read data, or a master-abort error, to the local requester.
- Used as the root-complex stand-in in system benches and as the host front end for link loopback builds.

---
 rtl/pcie_host_requester.sv | 160 ++++++++++++++++
 tb/tb_pcie_host_requester.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_host_requester.sv
// Host-side requester: queues local commands, serialises them as 64-bit link packets and
// tracks one outstanding read with a timeout. Define PCIE_HOST_WRITE_ACK_EN to ack writes.
module pcie_host_requester #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        link_valid_o,
  output logic [63:0] link_data_o,
  output logic        link_is_write_o,
  input  logic        cpl_valid_i,
  input  logic [31:0] cpl_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_error_o,
  output logic        busy_o
);
  // state    | meaning
  // IDLE     | popping queued commands; writes issue back to back
  // WAIT_CPL | one read on the link, waiting for its completion or timeout

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT_CPL = 1'b1} state_t;
  state_t state_q, state_d;

  // entry layout: {write, wdata, addr}
  logic [64:0]   fifo_q [CMD_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        link_valid_q, link_valid_d;
  logic [63:0] link_data_q, link_data_d;
  logic        link_is_write_q, link_is_write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;

  logic        push, pop, head_write, tmo_hit;
  logic [64:0] head;

  assign cmd_ready_o = (count_q != FULL_CNT);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign head_write  = head[64];
  assign tmo_hit     = (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_write_i, cmd_wdata_i, cmd_addr_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pop && !head_write) state_d = WAIT_CPL;
      WAIT_CPL: if (cpl_valid_i || tmo_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    link_valid_d    = 1'b0;
    link_data_d     = link_data_q;
    link_is_write_d = link_is_write_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    rsp_error_d     = rsp_error_q;
    tmo_d           = tmo_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          link_valid_d    = 1'b1;
          link_is_write_d = head_write;
          link_data_d     = head_write ? head[63:0] : {32'h0, head[31:0]};
          if (!head_write) tmo_d = '0;
`ifdef PCIE_HOST_WRITE_ACK_EN
          if (head_write) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'h0;
            rsp_error_d = 1'b0;
          end
`endif
        end
      end
      WAIT_CPL: begin
        // completion takes priority over a coincident timeout
        if (cpl_valid_i) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cpl_data_i;
          rsp_error_d = 1'b0;
        end else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'hFFFF_FFFF;
          rsp_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      link_valid_q    <= 1'b0;
      link_data_q     <= '0;
      link_is_write_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_error_q     <= 1'b0;
      tmo_q           <= '0;
    end else begin
      link_valid_q    <= link_valid_d;
      link_data_q     <= link_data_d;
      link_is_write_q <= link_is_write_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_error_q     <= rsp_error_d;
      tmo_q           <= tmo_d;
    end
  end

  assign link_valid_o    = link_valid_q;
  assign link_data_o     = link_data_q;
  assign link_is_write_o = link_is_write_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_error_o     = rsp_error_q;
  assign busy_o          = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_pcie_host_requester.sv
// Directed self-checking bench for pcie_host_requester (CMD_DEPTH=4, TIMEOUT_CYCLES=8).
module tb_pcie_host_requester;
`ifdef PCIE_HOST_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        link_valid, link_is_write;
  logic [63:0] link_data;
  logic        cpl_valid = 1'b0;
  logic [31:0] cpl_data = '0;
  logic        rsp_valid, rsp_error, busy;
  logic [31:0] rsp_data;

  int checks = 0;
  int fails  = 0;

  pcie_host_requester #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .link_valid_o(link_valid), .link_data_o(link_data), .link_is_write_o(link_is_write),
    .cpl_valid_i(cpl_valid), .cpl_data_i(cpl_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (link_valid !== 1'b0) begin fails++; $display("FAIL rst_link_valid: got %b want 0", link_valid); end
    checks++; if (link_data !== 64'h0) begin fails++; $display("FAIL rst_link_data: got %h want 0", link_data); end
    checks++; if (link_is_write !== 1'b0) begin fails++; $display("FAIL rst_is_write: got %b want 0", link_is_write); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin fails++; $display("FAIL rst_rsp_error: got %b want 0", rsp_error); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    checks++; if (link_valid !== 1'b0) begin fails++; $display("FAIL wr_early: got %b want 0", link_valid); end
    tick();
    checks++; if (link_valid !== 1'b1) begin fails++; $display("FAIL wr_pulse: got %b want 1", link_valid); end
    checks++; if (link_data !== 64'hDEAD_BEEF_0000_0010) begin fails++; $display("FAIL wr_data: got %h want deadbeef00000010", link_data); end
    checks++; if (link_is_write !== 1'b1) begin fails++; $display("FAIL wr_is_write: got %b want 1", link_is_write); end
    checks++; if (rsp_valid !== ACK) begin fails++; $display("FAIL wr_ack: got %b want %b", rsp_valid, ACK); end
    tick();
    checks++; if (link_valid !== 1'b0) begin fails++; $display("FAIL wr_pulse_end: got %b want 0", link_valid); end
    checks++; if (link_data !== 64'hDEAD_BEEF_0000_0010) begin fails++; $display("FAIL wr_data_hold: got %h", link_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    bit early;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h7777_7777;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (link_valid !== 1'b1) begin fails++; $display("FAIL rd_pulse: got %b want 1", link_valid); end
    checks++; if (link_data !== 64'h0000_0000_0000_0020) begin fails++; $display("FAIL rd_data: got %h want 20", link_data); end
    checks++; if (link_is_write !== 1'b0) begin fails++; $display("FAIL rd_is_write: got %b want 0", link_is_write); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rd_busy_wait: got %b want 1", busy); end
    early = 1'b0;
    tick(); if (rsp_valid) early = 1'b1;
    tick(); if (rsp_valid) early = 1'b1;
    checks++; if (early !== 1'b0) begin fails++; $display("FAIL rd_early_rsp: got %b want 0", early); end
    cpl_valid = 1'b1; cpl_data = 32'h1234_5678;
    tick();
    cpl_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h1234_5678) begin fails++; $display("FAIL rd_rsp_data: got %h want 12345678", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin fails++; $display("FAIL rd_rsp_error: got %b want 0", rsp_error); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_rsp_once: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h1234_5678) begin fails++; $display("FAIL rd_rsp_hold: got %h want 12345678", rsp_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    bit early;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (link_valid !== 1'b1 || link_is_write !== 1'b0) begin fails++; $display("FAIL to_pulse: got v=%b w=%b want v=1 w=0", link_valid, link_is_write); end
    early = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (rsp_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin fails++; $display("FAIL to_early: got %b want 0", early); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL to_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL to_rsp_data: got %h want ffffffff", rsp_data); end
    checks++; if (rsp_error !== 1'b1) begin fails++; $display("FAIL to_rsp_error: got %b want 1", rsp_error); end
    cpl_valid = 1'b1; cpl_data = 32'hAAAA_5555;
    tick();
    cpl_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL to_stray_cpl: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'hFFFF_FFFF || rsp_error !== 1'b1) begin fails++; $display("FAIL to_hold: got %h/%b want ffffffff/1", rsp_data, rsp_error); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", busy); end
  endtask

  // A read stalls the queue so six held writes fill it; then the read completes.
  task automatic test_back_to_back();
    int sent = 0, got = 0, reads = 0, rsps = 0, acks = 0, full_cyc = 0;
    int first_cyc = -1, last_cyc = -1, rsp_cyc = -1;
    bit cpl_sent = 1'b0, rdy, bad_order = 1'b0, bad_read = 1'b0;
    logic [63:0] exp;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
    tick();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (link_valid) begin
        if (link_is_write) begin
          exp = {32'hA000_0000 + 32'(got), 32'h100 + 32'(got * 4)};
          if (link_data !== exp) bad_order = 1'b1;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          got++;
        end else begin
          reads++;
          if (link_data !== 64'h40) bad_read = 1'b1;
        end
      end
      if (rsp_valid) begin
        if (link_valid && link_is_write) begin
          acks++;
        end else begin
          rsps++;
          rsp_cyc = cyc;
          checks++; if (rsp_data !== 32'h0BAD_F00D || rsp_error !== 1'b0) begin fails++; $display("FAIL b2b_rsp: got %h/%b want 0badf00d/0", rsp_data, rsp_error); end
        end
      end
      cmd_valid = (sent < 6);
      cmd_write = 1'b1;
      cmd_addr  = 32'h100 + 32'(sent * 4);
      cmd_wdata = 32'hA000_0000 + 32'(sent);
      rdy = cmd_ready;
      if (!rdy) full_cyc++;
      cpl_valid = (full_cyc == 2) && !cpl_sent;
      cpl_data  = 32'h0BAD_F00D;
      if (cpl_valid) cpl_sent = 1'b1;
      tick();
      if (cmd_valid && rdy) sent++;
      cpl_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    checks++; if (full_cyc < 1) begin fails++; $display("FAIL b2b_full: cmd_ready low cycles %0d want >=1", full_cyc); end
    checks++; if (sent !== 6) begin fails++; $display("FAIL b2b_sent: got %0d want 6", sent); end
    checks++; if (got !== 6) begin fails++; $display("FAIL b2b_issued: got %0d want 6", got); end
    checks++; if (bad_order !== 1'b0) begin fails++; $display("FAIL b2b_order: got %b want 0", bad_order); end
    checks++; if (last_cyc - first_cyc !== 5) begin fails++; $display("FAIL b2b_consec: span %0d want 5", last_cyc - first_cyc); end
    checks++; if (reads !== 1 || bad_read !== 1'b0) begin fails++; $display("FAIL b2b_read: got %0d bad=%b want 1/0", reads, bad_read); end
    checks++; if (rsps !== 1) begin fails++; $display("FAIL b2b_rsp_count: got %0d want 1", rsps); end
    checks++; if (first_cyc !== rsp_cyc + 1) begin fails++; $display("FAIL b2b_after_rsp: first write %0d want %0d", first_cyc, rsp_cyc + 1); end
    checks++; if (acks !== (ACK ? 6 : 0)) begin fails++; $display("FAIL b2b_acks: got %0d want %0d", acks, ACK ? 6 : 0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_ordering();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050;
    tick();
    cmd_write = 1'b1; cmd_addr = 32'h0000_0060; cmd_wdata = 32'hB0B0_B0B0;
    tick();
    cmd_valid = 1'b0;
    checks++; if (link_valid !== 1'b1 || link_data !== 64'h50) begin fails++; $display("FAIL ord_read: got v=%b d=%h want 1/50", link_valid, link_data); end
    tick();
    checks++; if (link_valid !== 1'b0) begin fails++; $display("FAIL ord_hold_b: got %b want 0", link_valid); end
    cpl_valid = 1'b1; cpl_data = 32'hCAFE_F00D;
    tick();
    cpl_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL ord_rsp: got v=%b d=%h want 1/cafef00d", rsp_valid, rsp_data); end
    checks++; if (link_valid !== 1'b0) begin fails++; $display("FAIL ord_gap: got %b want 0", link_valid); end
    tick();
    checks++; if (link_valid !== 1'b1 || link_is_write !== 1'b1) begin fails++; $display("FAIL ord_b_pulse: got v=%b w=%b want 1/1", link_valid, link_is_write); end
    checks++; if (link_data !== 64'hB0B0_B0B0_0000_0060) begin fails++; $display("FAIL ord_b_data: got %h want b0b0b0b000000060", link_data); end
    checks++; if (rsp_valid !== ACK) begin fails++; $display("FAIL ord_b_ack: got %b want %b", rsp_valid, ACK); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    bit seen_link = 1'b0, seen_rsp = 1'b0, seen_busy = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0070;
    tick();
    cmd_write = 1'b1; cmd_addr = 32'h0000_0074; cmd_wdata = 32'h1111_1111;
    tick();
    cmd_addr = 32'h0000_0078; cmd_wdata = 32'h2222_2222;
    tick();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mr_busy_pre: got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (link_valid !== 1'b0 || link_data !== 64'h0 || link_is_write !== 1'b0) begin fails++; $display("FAIL mr_link: got v=%b d=%h w=%b want 0/0/0", link_valid, link_data, link_is_write); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_error !== 1'b0) begin fails++; $display("FAIL mr_rsp: got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_data, rsp_error); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mr_busy: got %b want 0", busy); end
    cpl_valid = 1'b1; cpl_data = 32'h5555_5555;
    tick();
    cpl_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (link_valid) seen_link = 1'b1;
      if (rsp_valid) seen_rsp = 1'b1;
      if (busy) seen_busy = 1'b1;
      tick();
    end
    checks++; if (seen_rsp !== 1'b0) begin fails++; $display("FAIL mr_late_cpl: got %b want 0", seen_rsp); end
    checks++; if (seen_link !== 1'b0) begin fails++; $display("FAIL mr_flushed: got %b want 0", seen_link); end
    checks++; if (seen_busy !== 1'b0) begin fails++; $display("FAIL mr_busy_after: got %b want 0", seen_busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_ordering();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
